mac_stop_ctrl: RTL and testbench
================================

// Module: mac_stop_ctrl
// PURPOSE
//   Sequencer for the mac_stop_mem matrix store: computes C = A x B over M x K and K x N operands.
//   Per C element: drives A/B read addresses for K cycles, accumulates, then writes C[i][j].
//   Started by a one-cycle start; abortable at any time by stop. Owns the memory ports while busy.
// PARAMETERS
//   M                        4   rows of A and C
//   K                        4   cols of A / rows of B (accumulation length)
//   N                        4   cols of B and C
//   DATA_WIDTH_INIT_MATRIX   32  A/B element width, unsigned
//   DATA_WIDTH_RESULT_MATRIX 2*DATA_WIDTH_INIT_MATRIX+$clog2(K)  C element / accumulator width
// PORTS
//   clk          in   1    clock, all state on rising edge
//   reset        in   1    synchronous, active-high reset
//   start        in   1    begin a full C = A x B pass (honoured only in IDLE)
//   stop         in   1    abort the current pass
//   busy         out  1    high in MAC and WRITE states
//   done         out  1    one-cycle pulse: full pass completed
//   aborted      out  1    one-cycle pulse: pass terminated by stop
//   row_addr_a   out  $clog2(M)  A row (i);  col_addr_a out $clog2(K) A col (k)
//   row_addr_b   out  $clog2(K)  B row (k);  col_addr_b out $clog2(N) B col (j)
//   row_addr_c   out  $clog2(M)  C row (i);  col_addr_c out $clog2(N) C col (j)
//   matrix_a_re  out  1    A read enable;  matrix_b_re out 1 B read enable
//   matrix_c_we  out  1    C write enable
//   data_out_a   in   DATA_WIDTH_INIT_MATRIX    A read data (combinational from memory, same cycle)
//   data_out_b   in   DATA_WIDTH_INIT_MATRIX    B read data (same cycle)
//   data_in_c    out  DATA_WIDTH_RESULT_MATRIX  C write data (= accumulator)
// BEHAVIOUR
//   States: IDLE -> MAC -> WRITE -> (MAC | DONE) ; DONE -> IDLE ; ABORT -> IDLE.
//   Reset: state IDLE, i=j=k=0, acc=0; all outputs 0 (busy, done, aborted, re/we, addresses, data_in_c).
//   IDLE: re/we=0, addresses 0. stop=1 -> stay IDLE (stop beats start). else start=1 -> MAC, i=j=k=0.
//   MAC (one cycle per k): matrix_a_re=matrix_b_re=1; A addr (i,k), B addr (k,j).
//     acc <= (k==0 ? 0 : acc) + data_out_a*data_out_b; product 2*W unsigned, zero-extended to result width.
//     k<K-1: k<=k+1, stay MAC. k==K-1: k<=0 -> WRITE.
//   WRITE (one cycle): matrix_c_we=1, C addr (i,j), data_in_c=acc; re=0.
//     Then j<=j+1; j==N-1: j<=0, i<=i+1; i==M-1 && j==N-1 -> DONE, else -> MAC.
//   DONE: done=1 for exactly this cycle, busy=0 -> IDLE. start here ignored.
//   stop in MAC: current element discarded, no C write; next state ABORT.
//   stop in WRITE: the C write of that cycle still completes; next state ABORT.
//   ABORT: aborted=1 for one cycle, i=j=k=0, acc=0 -> IDLE. stop in DONE/ABORT: ignored.
//   start while busy: ignored (no restart). reset mid-pass: immediate return to reset state, no partial write.
//   Latency: start accepted cycle t -> first A/B read at t+1; done high at t+1+M*N*(K+1).
//   Outputs are decoded from registered state/counters only (no comb path from start/stop).
//   Counters wrap exactly at M/K/N (non-power-of-two sizes supported).
//   Overflow impossible: result width covers K unsigned full-scale products.
// TESTING
//   M=K=N=2,W=8: A=[[1,2],[3,4]], B=[[5,6],[7,8]], start at t -> C writes 19,22,43,50 at (0,0),(0,1),(1,0),(1,1); done at t+13.
//   All 0xFF operands, K=4 -> each C = 4*0xFE01 = 0x3F804, no truncation in data_in_c.
//   stop during 2nd MAC cycle of element (0,1) -> no write to (0,1), aborted pulse next cycle, busy drops, later start restarts at (0,0).
//   stop in WRITE of (1,0) -> (1,0) written, aborted pulse, no write to (1,1).
//   start pulsed repeatedly while busy and start+stop together in IDLE -> single pass / no pass respectively; done exactly once.
//   reset asserted mid-MAC -> next cycle all outputs 0, state IDLE; M=3,K=5,N=3 pass checks counter wrap & done at t+1+45*... = t+55.

Source files
------------

// File: rtl/mac_stop_ctrl.sv
// mac_stop_ctrl: sequencer that computes C = A x B through the mac_stop_mem
// memory ports, one C element at a time (K MAC cycles then one WRITE cycle).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, stop                begin a pass (IDLE only) / abort the pass
//   busy, done, aborted        status: busy in MAC/WRITE, one-cycle pulses
//   row/col_addr_a/b/c         element addresses for A, B and C
//   matrix_a_re/b_re/c_we      memory read and write enables
//   data_out_a, data_out_b     same-cycle read data from A and B
//   data_in_c                  C write data (the accumulator)
module mac_stop_ctrl #(
    parameter int M = 4,
    parameter int K = 4,
    parameter int N = 4,
    parameter int DATA_WIDTH_INIT_MATRIX = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX =
        2*DATA_WIDTH_INIT_MATRIX+$clog2(K)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic busy,
    output logic done,
    output logic aborted,
    output logic [(M>1?$clog2(M):1)-1:0] row_addr_a,
    output logic [(K>1?$clog2(K):1)-1:0] col_addr_a,
    output logic [(K>1?$clog2(K):1)-1:0] row_addr_b,
    output logic [(N>1?$clog2(N):1)-1:0] col_addr_b,
    output logic [(M>1?$clog2(M):1)-1:0] row_addr_c,
    output logic [(N>1?$clog2(N):1)-1:0] col_addr_c,
    output logic matrix_a_re,
    output logic matrix_b_re,
    output logic matrix_c_we,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0] data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0] data_out_b,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c
);

    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = DATA_WIDTH_INIT_MATRIX;
    localparam int RW = DATA_WIDTH_RESULT_MATRIX;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        WRITE,
        DONE,
        ABORT
    } state_t;

    state_t state;
    state_t nxt;

    logic [MW-1:0] i;
    logic [NW-1:0] j;
    logic [KW-1:0] k;
    logic [RW-1:0] acc;
    logic [2*DW-1:0] prod;

    logic k_last;
    logic j_last;
    logic i_last;

    assign k_last = (k == KW'(K-1));
    assign j_last = (j == NW'(N-1));
    assign i_last = (i == MW'(M-1));

    // Full-width unsigned product; operands widened first so no bits drop.
    assign prod = {{DW{1'b0}}, data_out_a} * {{DW{1'b0}}, data_out_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end
                end
                MAC: begin
                    if (stop) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end else begin
                        // k==0 restarts the sum for a fresh C element.
                        acc <= (k == '0 ? '0 : acc) + RW'(prod);
                        k   <= k_last ? '0 : k + 1'b1;
                    end
                end
                WRITE: begin
                    if (stop) begin
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end else if (j_last) begin
                        j <= '0;
                        i <= i_last ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                ABORT: begin
                    i   <= '0;
                    j   <= '0;
                    k   <= '0;
                    acc <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state and counters.
    always_comb begin
        nxt         = state;
        busy        = 1'b0;
        done        = 1'b0;
        aborted     = 1'b0;
        matrix_a_re = 1'b0;
        matrix_b_re = 1'b0;
        matrix_c_we = 1'b0;
        row_addr_a  = '0;
        col_addr_a  = '0;
        row_addr_b  = '0;
        col_addr_b  = '0;
        row_addr_c  = '0;
        col_addr_c  = '0;
        data_in_c   = '0;
        unique case (state)
            IDLE: begin
                if (start && !stop) nxt = MAC;
            end
            MAC: begin
                busy        = 1'b1;
                matrix_a_re = 1'b1;
                matrix_b_re = 1'b1;
                row_addr_a  = i;
                col_addr_a  = k;
                row_addr_b  = k;
                col_addr_b  = j;
                if (stop) nxt = ABORT;
                else if (k_last) nxt = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                matrix_c_we = 1'b1;
                row_addr_c  = i;
                col_addr_c  = j;
                data_in_c   = acc;
                if (stop) nxt = ABORT;
                else if (i_last && j_last) nxt = DONE;
                else nxt = MAC;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            ABORT: begin
                aborted = 1'b1;
                nxt     = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Testbench for mac_stop_ctrl (M=3, K=5, N=3, 8-bit operands) with a
// behavioural memory/matrix model and per-scenario checks.
module tb_mac_stop_ctrl;

    localparam int TM = 3;
    localparam int TK = 5;
    localparam int TN = 3;
    localparam int TW = 8;
    localparam int TR = 2*TW+$clog2(TK);
    localparam int EL = TK + 1;
    localparam int PASS_LAT = 1 + TM*TN*EL;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic busy, done, aborted;
    logic [1:0] row_addr_a;
    logic [2:0] col_addr_a;
    logic [2:0] row_addr_b;
    logic [1:0] col_addr_b;
    logic [1:0] row_addr_c;
    logic [1:0] col_addr_c;
    logic matrix_a_re, matrix_b_re, matrix_c_we;
    logic [TW-1:0] data_out_a, data_out_b;
    logic [TR-1:0] data_in_c;

    logic [TW-1:0] a_mem [TM][TK];
    logic [TW-1:0] b_mem [TK][TN];
    longint exp_c [TM][TN];

    int cyc = 0;
    int wr_r[$];
    int wr_c[$];
    int wr_t[$];
    logic [TR-1:0] wr_d[$];
    int done_q[$];
    int ab_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    mac_stop_ctrl #(
        .M(TM), .K(TK), .N(TN),
        .DATA_WIDTH_INIT_MATRIX(TW),
        .DATA_WIDTH_RESULT_MATRIX(TR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .busy(busy), .done(done), .aborted(aborted),
        .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
        .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
        .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
        .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re),
        .matrix_c_we(matrix_c_we),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .data_in_c(data_in_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign data_out_a = (matrix_a_re && row_addr_a < TM && col_addr_a < TK)
                        ? a_mem[row_addr_a][col_addr_a] : '0;
    assign data_out_b = (matrix_b_re && row_addr_b < TK && col_addr_b < TN)
                        ? b_mem[row_addr_b][col_addr_b] : '0;

    always @(negedge clk) begin
        if (matrix_c_we) begin
            wr_r.push_back(int'(row_addr_c));
            wr_c.push_back(int'(col_addr_c));
            wr_d.push_back(data_in_c);
            wr_t.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
        if (aborted) ab_q.push_back(cyc);
    end

    task automatic clear_log;
        wr_r.delete();
        wr_c.delete();
        wr_d.delete();
        wr_t.delete();
        done_q.delete();
        ab_q.delete();
    endtask

    task automatic fill(input bit ones);
        for (int r = 0; r < TM; r++)
            for (int c = 0; c < TK; c++)
                a_mem[r][c] = ones ? 8'hFF : TW'($urandom);
        for (int r = 0; r < TK; r++)
            for (int c = 0; c < TN; c++)
                b_mem[r][c] = ones ? 8'hFF : TW'($urandom);
        for (int r = 0; r < TM; r++)
            for (int c = 0; c < TN; c++) begin
                exp_c[r][c] = 0;
                for (int x = 0; x < TK; x++)
                    exp_c[r][c] += longint'(a_mem[r][x]) * longint'(b_mem[x][c]);
            end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives a one-cycle start; t is the cycle in which start is seen.
    task automatic start_pass(output int t);
        @(negedge clk);
        start = 1'b1;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cycles(3);
        n_cmp++;
        if ({busy, done, aborted, matrix_a_re, matrix_b_re, matrix_c_we} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got %b want 000000",
                     {busy, done, aborted, matrix_a_re, matrix_b_re, matrix_c_we});
        end
        n_cmp++;
        if ({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_addr got %h want 0",
                     {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c});
        end
        n_cmp++;
        if (data_in_c !== '0) begin
            n_bad++;
            $display("FAIL reset_data got %h want 0", data_in_c);
        end
        reset = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_full_pass(input bit ones);
        int t;
        fill(ones);
        clear_log();
        start_pass(t);
        n_cmp++;
        if ({busy, matrix_a_re, matrix_b_re, row_addr_a, col_addr_a, col_addr_b} !== {3'b111, 7'd0}) begin
            n_bad++;
            $display("FAIL first_read got %b want 1110000000",
                     {busy, matrix_a_re, matrix_b_re, row_addr_a, col_addr_a, col_addr_b});
        end
        wait_cycles(PASS_LAT + 5);
        n_cmp++;
        if (done_q.size() != 1) begin
            n_bad++;
            $display("FAIL pass_done_count got %0d want 1", done_q.size());
        end else begin
            n_cmp++;
            if (done_q[0] != t + PASS_LAT) begin
                n_bad++;
                $display("FAIL pass_done_time got %0d want %0d", done_q[0] - t, PASS_LAT);
            end
        end
        n_cmp++;
        if (wr_r.size() != TM*TN) begin
            n_bad++;
            $display("FAIL pass_writes got %0d want %0d", wr_r.size(), TM*TN);
        end
        for (int e = 0; e < wr_r.size() && e < TM*TN; e++) begin
            n_cmp++;
            if (wr_r[e] != e / TN || wr_c[e] != e % TN || wr_d[e] !== TR'(exp_c[e/TN][e%TN])) begin
                n_bad++;
                $display("FAIL pass_elem%0d got (%0d,%0d)=%h want (%0d,%0d)=%h", e,
                         wr_r[e], wr_c[e], wr_d[e], e/TN, e%TN, TR'(exp_c[e/TN][e%TN]));
            end
            n_cmp++;
            if (wr_t[e] != t + (e+1)*EL) begin
                n_bad++;
                $display("FAIL pass_time%0d got %0d want %0d", e, wr_t[e] - t, (e+1)*EL);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || ab_q.size() != 0) begin
            n_bad++;
            $display("FAIL pass_end busy=%b aborts=%0d want 0/0", busy, ab_q.size());
        end
    endtask

    task automatic test_stop_mac;
        int t;
        fill(1'b0);
        clear_log();
        start_pass(t);
        wait_cycles(EL + 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++;
        if ({aborted, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL stopmac_pulse got aborted/busy %b want 10", {aborted, busy});
        end
        wait_cycles(10);
        n_cmp++;
        if (wr_r.size() != 1) begin
            n_bad++;
            $display("FAIL stopmac_writes got %0d want 1", wr_r.size());
        end else begin
            n_cmp++;
            if (wr_r[0] != 0 || wr_c[0] != 0 || wr_d[0] !== TR'(exp_c[0][0])) begin
                n_bad++;
                $display("FAIL stopmac_elem got (%0d,%0d)=%h want (0,0)=%h",
                         wr_r[0], wr_c[0], wr_d[0], TR'(exp_c[0][0]));
            end
        end
        n_cmp++;
        if (ab_q.size() != 1 || done_q.size() != 0) begin
            n_bad++;
            $display("FAIL stopmac_pulses got aborts=%0d dones=%0d want 1/0",
                     ab_q.size(), done_q.size());
        end else begin
            n_cmp++;
            if (ab_q[0] != t + EL + 3) begin
                n_bad++;
                $display("FAIL stopmac_time got %0d want %0d", ab_q[0] - t, EL + 3);
            end
        end
    endtask

    task automatic test_stop_write;
        int t;
        fill(1'b0);
        clear_log();
        start_pass(t);
        wait_cycles(4*EL - 1);
        n_cmp++;
        if ({matrix_c_we, row_addr_c, col_addr_c} !== 5'b10100) begin
            n_bad++;
            $display("FAIL stopwr_pre got %b want 10100", {matrix_c_we, row_addr_c, col_addr_c});
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_cycles(10);
        n_cmp++;
        if (wr_r.size() != 4) begin
            n_bad++;
            $display("FAIL stopwr_writes got %0d want 4", wr_r.size());
        end else begin
            n_cmp++;
            if (wr_r[3] != 1 || wr_c[3] != 0 || wr_d[3] !== TR'(exp_c[1][0])) begin
                n_bad++;
                $display("FAIL stopwr_elem got (%0d,%0d)=%h want (1,0)=%h",
                         wr_r[3], wr_c[3], wr_d[3], TR'(exp_c[1][0]));
            end
        end
        n_cmp++;
        if (ab_q.size() != 1 || done_q.size() != 0) begin
            n_bad++;
            $display("FAIL stopwr_pulses got aborts=%0d dones=%0d want 1/0",
                     ab_q.size(), done_q.size());
        end else begin
            n_cmp++;
            if (ab_q[0] != t + 4*EL + 1) begin
                n_bad++;
                $display("FAIL stopwr_time got %0d want %0d", ab_q[0] - t, 4*EL + 1);
            end
        end
    endtask

    task automatic test_start_spam;
        int t;
        fill(1'b0);
        clear_log();
        start_pass(t);
        repeat (40) begin
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        wait_cycles(30);
        n_cmp++;
        if (done_q.size() != 1 || wr_r.size() != TM*TN) begin
            n_bad++;
            $display("FAIL spam_pass got dones=%0d writes=%0d want 1/%0d",
                     done_q.size(), wr_r.size(), TM*TN);
        end else begin
            n_cmp++;
            if (done_q[0] != t + PASS_LAT) begin
                n_bad++;
                $display("FAIL spam_done_time got %0d want %0d", done_q[0] - t, PASS_LAT);
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL startstop_busy got %b want 0", busy);
        end
        wait_cycles(10);
        n_cmp++;
        if (done_q.size() != 1 || wr_r.size() != TM*TN || ab_q.size() != 0) begin
            n_bad++;
            $display("FAIL startstop_idle got dones=%0d writes=%0d aborts=%0d want 1/%0d/0",
                     done_q.size(), wr_r.size(), ab_q.size(), TM*TN);
        end
    endtask

    task automatic test_reset_mid;
        int t;
        fill(1'b0);
        clear_log();
        start_pass(t);
        wait_cycles(2);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, aborted, matrix_a_re, matrix_b_re, matrix_c_we} !== 6'b0) begin
            n_bad++;
            $display("FAIL midreset_ctl got %b want 000000",
                     {busy, done, aborted, matrix_a_re, matrix_b_re, matrix_c_we});
        end
        n_cmp++;
        if ({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c} !== 14'd0
            || data_in_c !== '0) begin
            n_bad++;
            $display("FAIL midreset_bus got addr %h data %h want 0/0",
                     {row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c},
                     data_in_c);
        end
        reset = 1'b0;
        wait_cycles(PASS_LAT + 5);
        n_cmp++;
        if (wr_r.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_after got writes=%0d dones=%0d busy=%b want 0/0/0",
                     wr_r.size(), done_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass(1'b0);
        test_full_pass(1'b0);
        test_full_pass(1'b1);
        test_stop_mac();
        test_full_pass(1'b0);
        test_stop_write();
        test_full_pass(1'b0);
        test_start_spam();
        test_reset_mid();
        test_full_pass(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
